// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-shared FIR filter:
//   - SAMPLE_W / COEF_W / PROD_W : operand and product widths
//   - state_t                    : controller states (IDLE, MAC, DONE)
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int SAMPLE_W = 8;
    localparam int COEF_W   = 8;
    localparam int PROD_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult.sv
// ---------------------------------------------------------------------------
// booth_mult
// Combinational radix-4 Booth multiplier, signed 8x8 -> signed 16.
// Ports:
//   a : signed multiplicand (sample)
//   b : signed multiplier (coefficient), recoded in 2-bit Booth digits
//   p : signed product
// ---------------------------------------------------------------------------
module booth_mult
    import fir_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [COEF_W-1:0]   b,
    output logic signed [PROD_W-1:0]   p
);

    logic [COEF_W:0]          b_ext;
    logic signed [PROD_W-1:0] a_ext;

    // Each overlapping 3-bit window of {b,0} selects 0, +-a or +-2a weighted
    // by 4^i. The product fits in PROD_W, so modulo-2^16 summation is exact.
    always_comb begin
        b_ext = {b, 1'b0};
        a_ext = {{(PROD_W - SAMPLE_W){a[SAMPLE_W-1]}}, a};
        p     = '0;
        for (int i = 0; i < COEF_W / 2; i++) begin
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: p = p + (a_ext <<< (2 * i));
                3'b011:         p = p + (a_ext <<< (2 * i + 1));
                3'b100:         p = p - (a_ext <<< (2 * i + 1));
                3'b101, 3'b110: p = p - (a_ext <<< (2 * i));
                default:        p = p;
            endcase
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// ---------------------------------------------------------------------------
// fir_mac_sched
// FIR filter that shares a single 8x8 multiplier across NTAPS taps, producing
// one product per cycle. A sample is accepted in IDLE, NTAPS MAC cycles follow,
// and the result is presented in DONE until the consumer takes it.
//
// Parameters:
//   NTAPS : number of taps (power of two, 2..16)
//   ACC_W : accumulator / result width (16 + log2 NTAPS)
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake, in_data signed 8-bit sample
//   coef_we/addr/data   : coefficient write port, honoured only in IDLE
//   out_valid/out_ready : result handshake, out_data signed ACC_W result
//   busy                : high whenever the controller is not in IDLE
//
// Build option: define FIR_SAT_EN to clamp the result to [-32768, 32767].
// ---------------------------------------------------------------------------
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int ACC_W = 19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    output logic                       busy
);

    localparam int               TAP_W    = $clog2(NTAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

    state_t state;
    state_t next_state;

    logic signed [SAMPLE_W-1:0] x [NTAPS];
    logic signed [COEF_W-1:0]   c [NTAPS];
    logic signed [ACC_W-1:0]    acc;
    logic [TAP_W-1:0]           tap;

    logic signed [SAMPLE_W-1:0] x_sel;
    logic signed [COEF_W-1:0]   c_sel;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    final_sum;
    logic                       last_tap;
    logic                       accept;

    assign accept   = in_valid && in_ready;
    assign last_tap = (tap == LAST_TAP);

    // Operand muxes pick the current tap out of the register files.
    assign x_sel = x[tap];
    assign c_sel = c[tap];

    booth_mult u_mult (
        .a (x_sel),
        .b (c_sel),
        .p (prod)
    );

    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = acc + prod_ext;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    always_comb begin
        final_sum = sum;
        if (sum > SAT_MAX) begin
            final_sum = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            final_sum = SAT_MIN;
        end
    end
`else
    assign final_sum = sum;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = MAC;
            MAC:     if (last_tap)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Handshake outputs. in_ready is gated by rst_n so it drops the moment
    // reset is asserted, not one edge later.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: delay line, coefficient file, accumulator and result.
    // Coefficient writes share the IDLE cycle with a sample accept, so a
    // coefficient written on the accept edge is already in place for tap 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc      <= '0;
            tap      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        c[coef_addr] <= coef_data;
                    end
                    if (accept) begin
                        x[0] <= in_data;
                        for (int k = 1; k < NTAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= sum;
                    tap <= tap + 1'b1;
                    if (last_tap) begin
                        out_data <= final_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sched
// Scoreboard bench for fir_mac_sched. Stimulus tasks update a behavioural
// model (sample history + coefficient array, direct sum of products) and push
// the expected result; an independent monitor pops and compares whenever a
// result is handed over, and also checks latency and hold-while-stalled.
// ---------------------------------------------------------------------------
module tb_fir_mac_sched;

    localparam int NTAPS = 8;
    localparam int ACC_W = 19;
    localparam int TAP_W = $clog2(NTAPS);
    localparam int LAT   = NTAPS + 1;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b1;
    logic                    in_valid  = 1'b0;
    logic                    in_ready;
    logic signed [7:0]       in_data   = '0;
    logic                    coef_we   = 1'b0;
    logic [TAP_W-1:0]        coef_addr = '0;
    logic signed [7:0]       coef_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    fir_mac_sched #(
        .NTAPS (NTAPS),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int acc_cycle;
    } exp_t;

    exp_t sb[$];
    int   hist[NTAPS];
    int   coef[NTAPS];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;
    bit   rand_rdy    = 1'b0;

    always @(posedge clk) cycle++;

    // Reference: y = sum c[k]*x[n-k], optionally clamped to 16-bit range.
    function automatic int refFilter();
        int s;
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            s += coef[k] * hist[k];
        end
`ifdef FIR_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s;
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: latency on rising out_valid, data hold while stalled, and
    // scoreboard comparison on each completed output handshake.
    initial begin : monitor
        bit                      prev_valid;
        bit                      prev_ready;
        logic signed [ACC_W-1:0] prev_data;
        exp_t                    e;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (out_valid && !prev_valid && sb.size() != 0) begin
                checkOutput("latency", longint'(cycle - sb[0].acc_cycle), longint'(LAT));
            end
            if (out_valid && prev_valid && !prev_ready) begin
                checkOutput("hold_data", longint'(out_data), longint'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got %0d, expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", longint'(out_data), longint'(e.value));
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    // Randomised consumer backpressure while rand_rdy is set.
    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        sb.delete();
        for (int k = 0; k < NTAPS; k++) begin
            hist[k] = 0;
            coef[k] = 0;
        end
        @(negedge clk);
        checkOutput("reset_in_ready", longint'(in_ready), 0);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportTimeout("wait_idle");
    endtask

    // Only called while the DUT is known to be idle.
    task automatic writeCoef(input int addr, input int val);
        @(posedge clk);
        #2;
        coef_we   = 1'b1;
        coef_addr = TAP_W'(addr);
        coef_data = 8'(val);
        @(posedge clk);
        coef[addr] = val;
        #2;
        coef_we = 1'b0;
    endtask

    task automatic setAllCoef(input int val);
        waitIdle();
        for (int k = 0; k < NTAPS; k++) writeCoef(k, val);
    endtask

    // Offers one sample (optionally with a coefficient write held alongside)
    // until it is accepted, then updates the model and scoreboard.
    task automatic applyStimulus(input int sample, input bit we, input int addr,
                                 input int cval, output int acc_cycle);
        bit   ok;
        exp_t e;
        ok        = 1'b0;
        acc_cycle = -1;
        @(posedge clk);
        #2;
        in_valid  = 1'b1;
        in_data   = 8'(sample);
        coef_we   = we;
        coef_addr = TAP_W'(addr);
        coef_data = 8'(cval);
        repeat (400) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            reportTimeout("accept");
        end else begin
            acc_cycle = cycle;
            if (we) coef[addr] = cval;
            for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0]     = sample;
            e.value     = refFilter();
            e.acc_cycle = cycle;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    initial begin : stimulus
        int                      ac[NTAPS];
        int                      dummy;
        bit                      seen;
        bit                      ok;
        logic signed [ACC_W-1:0] held;
        int                      s;

        for (int k = 0; k < NTAPS; k++) begin
            hist[k] = 0;
            coef[k] = 0;
        end

        // Power-on reset and post-release state.
        #3 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("por_in_ready_low", longint'(in_ready), 0);
        checkOutput("por_busy", longint'(busy), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_in_ready", longint'(in_ready), 1);
        checkOutput("rel_out_valid", longint'(out_valid), 0);
        checkOutput("rel_busy", longint'(busy), 0);
        checkOutput("rel_out_data", longint'(out_data), 0);

        // Zero coefficients give zero output; check MAC-state flags.
        applyStimulus(5, 1'b0, 0, 0, dummy);
        @(negedge clk);
        checkOutput("mac_busy", longint'(busy), 1);
        checkOutput("mac_in_ready", longint'(in_ready), 0);
        waitIdle();

        // Unit coefficients: running sums 1,3,6,...,36 at full throughput.
        doReset();
        setAllCoef(1);
        for (int i = 0; i < NTAPS; i++) applyStimulus(i + 1, 1'b0, 0, 0, ac[i]);
        waitIdle();
        for (int i = 1; i < NTAPS; i++) begin
            checkOutput("throughput", longint'(ac[i] - ac[i-1]), longint'(NTAPS + 2));
        end

        // Extreme single-tap products.
        waitIdle();
        writeCoef(0, -128);
        for (int k = 1; k < NTAPS; k++) writeCoef(k, 0);
        applyStimulus(-128, 1'b0, 0, 0, dummy);
        applyStimulus(127, 1'b0, 0, 0, dummy);

        // Full-scale accumulation (saturates when FIR_SAT_EN is defined).
        setAllCoef(127);
        for (int i = 0; i < NTAPS; i++) applyStimulus(127, 1'b0, 0, 0, dummy);
        setAllCoef(-128);
        for (int i = 0; i < NTAPS; i++) applyStimulus(127, 1'b0, 0, 0, dummy);

        // Coefficient write and sample accept in the same IDLE cycle.
        setAllCoef(2);
        applyStimulus(10, 1'b1, 0, -5, dummy);
        waitIdle();

        // Backpressure in DONE; a coefficient write there must be dropped.
        setAllCoef(1);
        @(posedge clk);
        #2 out_ready = 1'b0;
        applyStimulus(20, 1'b0, 0, 0, dummy);
        ok = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportTimeout("done_wait");
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            coef_we   = (i == 1);
            coef_addr = '0;
            coef_data = 8'sd9;
            @(negedge clk);
            checkOutput("stall_out_valid", longint'(out_valid), 1);
            checkOutput("stall_in_ready", longint'(in_ready), 0);
            checkOutput("stall_out_data", longint'(out_data), longint'(held));
        end
        @(posedge clk);
        #2;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        applyStimulus(-3, 1'b0, 0, 0, dummy);
        waitIdle();

        // Reset at MAC tap 3 discards the result and clears all state.
        setAllCoef(3);
        applyStimulus(7, 1'b0, 0, 0, dummy);
        repeat (2) @(posedge clk);
        doReset();
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("no_output_after_reset", longint'(seen), 0);
        applyStimulus(4, 1'b0, 0, 0, dummy);
        setAllCoef(1);
        applyStimulus(0, 1'b0, 0, 0, dummy);
        waitIdle();

        // Random coefficients, samples, mid-accept writes and backpressure.
        for (int k = 0; k < NTAPS; k++) writeCoef(k, int'($urandom_range(0, 255)) - 128);
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 255)) - 128;
            applyStimulus(s, ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, NTAPS - 1)),
                          int'($urandom_range(0, 255)) - 128, dummy);
        end
        waitIdle();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
